// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide unit.
// Op encodings follow funct3 of OP instructions with funct7=0000001.
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_DIV  = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// quot_o/rem_o show the values the current step will produce, so the caller can capture the final step.
module muldiv_div_core #(
    parameter int WIDTH = 32,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             last_o
);

    localparam int CW = $clog2(ITERS + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             fits;

    // One extra bit keeps the compare exact for divisors above 2^(WIDTH-1).
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    assign fits      = !diff[WIDTH];
    assign rem_o     = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quot_o    = {quo_q[WIDTH-2:0], fits};
    assign last_o    = (cnt_q == CW'(ITERS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
        end else if (step_i) begin
            rem_q <= rem_o;
            quo_q <= quot_o;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M multiply/divide unit: single-cycle multiply, iterative divide, pipeline stall.
//   state   | meaning
//   IDLE    | no op in flight; multiplies and divide special cases resolve on the start edge
//   DIV     | divider iterating, pipeline held
//   DONE    | result_o valid for one cycle, pipeline advances
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_ITERS  = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int         W      = DATA_WIDTH;
    localparam logic [1:0] S_IDLE = MD_IDLE;
    localparam logic [1:0] S_DIV  = MD_DIV;
    localparam logic [1:0] S_DONE = MD_DONE;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    muldiv_op_e   op;
    logic [1:0]   state_q;
    logic         go;
    logic         is_div;
    logic         is_rem_op;
    logic         div_signed;
    logic         a_signed;
    logic         b_signed;
    logic [2*W-1:0] mul_a;
    logic [2*W-1:0] mul_b;
    logic [2*W-1:0] prod;
    logic [W-1:0] mul_res;
    logic         rs1_neg;
    logic         rs2_neg;
    logic [W-1:0] rs1_mag;
    logic [W-1:0] rs2_mag;
    logic         div_by_zero;
    logic         div_ovf;
    logic         div_load;
    logic         div_last;
    logic [W-1:0] quot_next;
    logic [W-1:0] rem_next;
    logic [W-1:0] div_res;
    logic         neg_q_q;
    logic         neg_r_q;
    logic         rem_sel_q;

    assign op         = muldiv_op_e'(op_i);
    assign go         = (state_q == S_IDLE) && start_i && !flush_i;
    assign is_div     = op_i[2];
    assign is_rem_op  = op_i[1];
    assign div_signed = (op == OP_DIV) || (op == OP_REM);
    assign a_signed   = (op == OP_MULH) || (op == OP_MULHSU);
    assign b_signed   = (op == OP_MULH);

    // Operands extended to the full product width so the low 2W bits of an unsigned multiply are exact.
    assign mul_a   = {{W{a_signed & rs1_i[W-1]}}, rs1_i};
    assign mul_b   = {{W{b_signed & rs2_i[W-1]}}, rs2_i};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];

    assign rs1_neg     = div_signed & rs1_i[W-1];
    assign rs2_neg     = div_signed & rs2_i[W-1];
    assign rs1_mag     = rs1_neg ? -rs1_i : rs1_i;
    assign rs2_mag     = rs2_neg ? -rs2_i : rs2_i;
    assign div_by_zero = (rs2_i == '0);
    assign div_ovf     = div_signed && (rs1_i == MIN_NEG) && (rs2_i == '1);
    assign div_load    = go && is_div && !div_by_zero && !div_ovf;

    assign div_res = rem_sel_q ? (neg_r_q ? -rem_next : rem_next)
                               : (neg_q_q ? -quot_next : quot_next);

    muldiv_div_core #(
        .WIDTH (W),
        .ITERS (DIV_ITERS)
    ) u_div_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (div_load),
        .step_i     (state_q == S_DIV),
        .dividend_i (rs1_mag),
        .divisor_i  (rs2_mag),
        .quot_o     (quot_next),
        .rem_o      (rem_next),
        .last_o     (div_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_o  <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        if (!is_div) begin
                            result_o <= mul_res;
                            state_q  <= S_DONE;
                        end else if (div_by_zero) begin
                            result_o <= is_rem_op ? rs1_i : '1;
                            state_q  <= S_DONE;
                        end else if (div_ovf) begin
                            result_o <= is_rem_op ? '0 : MIN_NEG;
                            state_q  <= S_DONE;
                        end else begin
                            neg_q_q   <= rs1_neg ^ rs2_neg;
                            neg_r_q   <= rs1_neg;
                            rem_sel_q <= is_rem_op;
                            state_q   <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else if (div_last) begin
                        result_o <= div_res;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall_o = go || (state_q == S_DIV);
    assign done_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit with hand-computed RV32M results.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int passes = 0;
    logic [31:0] last_exp;

    vec_t mul_vecs [6] = '{
        '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{OP_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
        '{OP_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006}
    };

    vec_t div_vecs [8] = '{
        '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{OP_DIVU, 32'd100,       32'd7,         32'd14},
        '{OP_REMU, 32'd100,       32'd7,         32'd2},
        '{OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001},
        '{OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE},
        '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
        '{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001}
    };

    vec_t spc_vecs [6] = '{
        '{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF},
        '{OP_REMU, 32'd5,         32'd0,         32'd5},
        '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
        '{OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF},
        '{OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9}
    };

    ex_muldiv_unit #(
        .DATA_WIDTH (32),
        .DIV_ITERS  (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op, hold start until done, then drop start after the DONE edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int cyc, output int stalls,
                          output logic done_after);
        res = '0;
        cyc = 0;
        stalls = 0;
        @(negedge clk);
        op_i = op;
        rs1_i = a;
        rs2_i = b;
        start_i = 1'b1;
        #1;
        for (int i = 1; i <= 60; i++) begin
            if (stall_o) stalls++;
            @(posedge clk);
            #1;
            if (done_o) begin
                cyc = i;
                res = result_o;
                break;
            end
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        done_after = done_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i = 3'b000;
        rs1_i = '0;
        rs2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result_o !== 32'h0) $display("FAIL reset_result: got %h expected %h", result_o, 32'h0);
        else passes++;
        checks++;
        if (done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_o);
        else passes++;
        checks++;
        if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_o);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors(input string name, input int n, input int lat, input int which);
        logic [31:0] res;
        int cyc;
        int stalls;
        logic done_after;
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = (which == 0) ? mul_vecs[i] : (which == 1) ? div_vecs[i] : spc_vecs[i];
            run_op(v.op, v.a, v.b, res, cyc, stalls, done_after);
            last_exp = v.exp;
            checks++;
            if (res !== v.exp) $display("FAIL %s_result[%0d]: got %h expected %h", name, i, res, v.exp);
            else passes++;
            checks++;
            if (cyc != lat) $display("FAIL %s_latency[%0d]: got %0d expected %0d", name, i, cyc, lat);
            else passes++;
            checks++;
            if (stalls != lat) $display("FAIL %s_stall_cycles[%0d]: got %0d expected %0d", name, i, stalls, lat);
            else passes++;
            checks++;
            if (done_after !== 1'b0) $display("FAIL %s_done_pulse[%0d]: got %b expected 0", name, i, done_after);
            else passes++;
        end
    endtask

    task automatic test_mul();
        test_vectors("mul", 6, 1, 0);
    endtask

    task automatic test_div();
        test_vectors("div", 8, 33, 1);
    endtask

    task automatic test_special();
        test_vectors("special", 6, 1, 2);
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int cyc;
        int stalls;
        int dones;
        logic done_after;
        @(negedge clk);
        op_i = OP_DIV;
        rs1_i = 32'd1000;
        rs2_i = 32'd3;
        start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b1) $display("FAIL flush_pre_stall: got %b expected 1", stall_o);
        else passes++;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        checks++;
        if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall_o);
        else passes++;
        checks++;
        if (done_o !== 1'b0) $display("FAIL flush_done: got %b expected 0", done_o);
        else passes++;
        checks++;
        if (result_o !== last_exp) $display("FAIL flush_result_hold: got %h expected %h", result_o, last_exp);
        else passes++;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) dones++;
        end
        checks++;
        if (dones != 0) $display("FAIL flush_no_done: got %0d pulses expected 0", dones);
        else passes++;
        // flush in the start cycle must win over start
        start_i = 1'b1;
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) $display("FAIL flush_start_stall: got %b expected 0", stall_o);
        else passes++;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        checks++;
        if (done_o !== 1'b0) $display("FAIL flush_start_done: got %b expected 0", done_o);
        else passes++;
        run_op(OP_DIVU, 32'd9, 32'd3, res, cyc, stalls, done_after);
        checks++;
        if (res !== 32'd3) $display("FAIL after_flush_result: got %h expected %h", res, 32'd3);
        else passes++;
        checks++;
        if (cyc != 33) $display("FAIL after_flush_latency: got %0d expected 33", cyc);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        op_i = OP_DIV;
        rs1_i = 32'd20;
        rs2_i = 32'd4;
        start_i = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc != 33) $display("FAIL b2b_div_latency: got %0d expected 33", cyc);
        else passes++;
        checks++;
        if (result_o !== 32'd5) $display("FAIL b2b_div_result: got %h expected %h", result_o, 32'd5);
        else passes++;
        @(posedge clk);
        #1;
        op_i = OP_MUL;
        rs1_i = 32'd6;
        rs2_i = 32'd7;
        checks++;
        if (done_o !== 1'b0) $display("FAIL b2b_bubble_done: got %b expected 0", done_o);
        else passes++;
        checks++;
        if (stall_o !== 1'b1) $display("FAIL b2b_bubble_stall: got %b expected 1", stall_o);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b1) $display("FAIL b2b_mul_done: got %b expected 1", done_o);
        else passes++;
        checks++;
        if (result_o !== 32'd42) $display("FAIL b2b_mul_result: got %h expected %h", result_o, 32'd42);
        else passes++;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b0) $display("FAIL b2b_mul_pulse: got %b expected 0", done_o);
        else passes++;
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] res;
        int cyc;
        int stalls;
        logic done_after;
        @(negedge clk);
        op_i = OP_DIVU;
        rs1_i = 32'd1000;
        rs2_i = 32'd3;
        start_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (result_o !== 32'h0) $display("FAIL rst_mid_result: got %h expected %h", result_o, 32'h0);
        else passes++;
        checks++;
        if (done_o !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", done_o);
        else passes++;
        checks++;
        if (stall_o !== 1'b0) $display("FAIL rst_mid_stall: got %b expected 0", stall_o);
        else passes++;
        rst_n = 1'b1;
        run_op(OP_MUL, 32'd6, 32'd7, res, cyc, stalls, done_after);
        checks++;
        if (res !== 32'd42) $display("FAIL rst_recover_result: got %h expected %h", res, 32'd42);
        else passes++;
    endtask

    initial begin
        last_exp = '0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d of %0d done", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
